// File: rtl/led_pkg.sv
// Shared LED-panel definitions: geometry, RGB444 pixel layout, gamma table and swap FSM encoding.
package led_pkg;

    localparam int PANEL_W   = 64;
    localparam int HALF_ROWS = 32;
    localparam int CH_DEPTH  = 4;

    localparam int COL_W   = 6;
    localparam int ROW_W   = 5;
    localparam int FRAME_W = 13;
    localparam int PIX_W   = 3 * CH_DEPTH;
    localparam int BANK_AW = ROW_W + COL_W;
    localparam int RAM_AW  = BANK_AW + 1;

    localparam logic [COL_W-1:0] COL_LAST = 6'd63;

    typedef logic [CH_DEPTH-1:0] chan_t;

    typedef struct packed {
        chan_t r;
        chan_t g;
        chan_t b;
    } pixel_t;

    typedef enum logic [1:0] {
        SWAP_IDLE    = 2'd0,
        SWAP_PENDING = 2'd1,
        SWAP_DO      = 2'd2
    } swap_state_t;

    // Perceptual correction applied ahead of the PWM compare in gamma builds.
    function automatic chan_t gamma_map(input chan_t c);
        chan_t g;
        case (c)
            4'd0:    g = 4'd0;
            4'd1:    g = 4'd0;
            4'd2:    g = 4'd0;
            4'd3:    g = 4'd1;
            4'd4:    g = 4'd1;
            4'd5:    g = 4'd2;
            4'd6:    g = 4'd2;
            4'd7:    g = 4'd3;
            4'd8:    g = 4'd4;
            4'd9:    g = 4'd5;
            4'd10:   g = 4'd6;
            4'd11:   g = 4'd8;
            4'd12:   g = 4'd9;
            4'd13:   g = 4'd11;
            4'd14:   g = 4'd13;
            4'd15:   g = 4'd15;
            default: g = 4'd0;
        endcase
        return g;
    endfunction

    function automatic logic pwm_lit(input chan_t c, input chan_t phase);
        return (c > phase);
    endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// Two-bank pixel store: one write port, one registered read port; bank select is the address MSB.
module fb_bank_ram
    import led_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [RAM_AW-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem_r [0:(1 << RAM_AW)-1];
    logic [PIX_W-1:0] rd_data_q;

    // Block-RAM style write and registered read; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_r[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fb_painter.sv
// Double-buffered RGB444 framebuffer for one LED panel half with PWM colour output.
// Build option FB_GAMMA_EN: channels pass through led_pkg::gamma_map before the PWM compare.
module fb_painter
    import led_pkg::*;
#(
    parameter int HALF  = 0,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [12:0]  frame,
    input  logic [7:0]   subframe,
    input  logic [5:0]   x,
    input  logic [5:0]   y,
    output logic [2:0]   rgb,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [5:0]   wr_x,
    input  logic [5:0]   wr_y,
    input  logic [11:0]  wr_data,
    input  logic         swap_req,
    output logic         swap_ack
);

    localparam logic HALF_BIT = 1'(HALF);

    swap_state_t          state_q, state_d;
    logic [FRAME_W-1:0]   frame_q;
    logic                 front_q, front_d;
    logic                 shown_q, shown_d;
    logic                 boundary_s;

    logic                 wr_fire_s;
    logic                 wr_en_q, wr_en_d;
    logic [RAM_AW-1:0]    wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]     wr_data_q, wr_data_d;

    logic [ROW_W-1:0]     rd_row_s;
    logic [COL_W-1:0]     rd_col_s;
    logic [RAM_AW-1:0]    rd_addr_s;
    logic [PIX_W-1:0]     rd_data_s;

    pixel_t               pix_s;
    chan_t                ch_r_s, ch_g_s, ch_b_s;
    logic [DEPTH-1:0]     phase_s;
    logic                 lit_en_s;
    logic                 unused_s;

    assign boundary_s = (frame != frame_q);
    assign phase_s    = subframe[DEPTH-1:0];
    assign unused_s   = ^subframe[7:DEPTH];

    // Swap FSM state plus the bank-select and display-enable flags it owns.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SWAP_IDLE;
            front_q <= 1'b0;
            shown_q <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            shown_q <= shown_d;
        end
    end

    // Swap FSM next state: a request waits for the next frame-counter change.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SWAP_IDLE: begin
                if (swap_req) begin
                    state_d = SWAP_PENDING;
                end else begin
                    state_d = SWAP_IDLE;
                end
            end
            SWAP_PENDING: begin
                if (boundary_s) begin
                    state_d = SWAP_DO;
                end else begin
                    state_d = SWAP_PENDING;
                end
            end
            SWAP_DO: begin
                state_d = SWAP_IDLE;
            end
            default: begin
                state_d = SWAP_IDLE;
            end
        endcase
    end

    // Swap FSM outputs: writes blocked until the swap completes, bank flips on the boundary.
    always_comb begin
        wr_ready = 1'b0;
        swap_ack = 1'b0;
        front_d  = front_q;
        shown_d  = shown_q;
        case (state_q)
            SWAP_IDLE: begin
                wr_ready = 1'b1;
            end
            SWAP_PENDING: begin
                if (boundary_s) begin
                    front_d = ~front_q;
                    shown_d = 1'b1;
                end else begin
                    front_d = front_q;
                    shown_d = shown_q;
                end
            end
            SWAP_DO: begin
                swap_ack = 1'b1;
            end
            default: begin
                wr_ready = 1'b0;
            end
        endcase
    end

    // Host write filter: every transfer is handshaken, only rows of this half reach the back bank.
    always_comb begin
        wr_fire_s = wr_valid & wr_ready;
        if (wr_fire_s && (wr_y[5] == HALF_BIT)) begin
            wr_en_d = 1'b1;
        end else begin
            wr_en_d = 1'b0;
        end
        wr_addr_d = {~front_q, wr_y[ROW_W-1:0], wr_x};
        wr_data_d = wr_data;
    end

    // Frame history for boundary detection and the one-cycle write pipeline into the RAM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            frame_q   <= frame;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Read one pixel ahead so the registered RAM output lines up with the presented x,y.
    always_comb begin
        if (x == COL_LAST) begin
            rd_row_s = y[ROW_W-1:0] + 5'd1;
            rd_col_s = 6'd0;
        end else begin
            rd_row_s = y[ROW_W-1:0];
            rd_col_s = x + 6'd1;
        end
        rd_addr_s = {front_q, rd_row_s, rd_col_s};
    end

    fb_bank_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_en_q),
        .wr_addr (wr_addr_q),
        .wr_data (wr_data_q),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // PWM compare; dark until the first swap and for rows belonging to the other half.
    always_comb begin
        pix_s = pixel_t'(rd_data_s);
`ifdef FB_GAMMA_EN
        ch_r_s = gamma_map(pix_s.r);
        ch_g_s = gamma_map(pix_s.g);
        ch_b_s = gamma_map(pix_s.b);
`else
        ch_r_s = pix_s.r;
        ch_g_s = pix_s.g;
        ch_b_s = pix_s.b;
`endif
        if (shown_q && (y[5] == HALF_BIT)) begin
            lit_en_s = 1'b1;
        end else begin
            lit_en_s = 1'b0;
        end
        rgb = {lit_en_s & pwm_lit(ch_r_s, phase_s),
               lit_en_s & pwm_lit(ch_g_s, phase_s),
               lit_en_s & pwm_lit(ch_b_s, phase_s)};
    end

endmodule

// File: tb/tb_fb_painter.sv
// Directed bench for fb_painter: HALF=0 and HALF=1 instances share all inputs.
module tb_fb_painter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [12:0] frame;
    logic [7:0]  subframe;
    logic [5:0]  x, y;
    logic        wr_valid;
    logic [5:0]  wr_x, wr_y;
    logic [11:0] wr_data;
    logic        swap_req;
    logic [2:0]  rgb0, rgb1;
    logic        wr_ready0, wr_ready1, swap_ack0, swap_ack1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fb_painter #(.HALF(0), .DEPTH(4)) dut0 (
        .clk(clk), .resetn(resetn), .frame(frame), .subframe(subframe), .x(x), .y(y),
        .rgb(rgb0), .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack0)
    );

    fb_painter #(.HALF(1), .DEPTH(4)) dut1 (
        .clk(clk), .resetn(resetn), .frame(frame), .subframe(subframe), .x(x), .y(y),
        .rgb(rgb1), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] px, input logic [5:0] py, input logic [11:0] d);
        bit ok = 1'b0;
        wr_valid = 1'b1;
        wr_x     = px;
        wr_y     = py;
        wr_data  = d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wr_ready0 && wr_ready1) ok = 1'b1;
            step();
            if (ok) break;
        end
        wr_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL write_handshake: x=%0d y=%0d got no ready, required ready", px, py);
        end
    endtask

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (swap_ack0 && swap_ack1) begin
                got = 1'b1;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic do_swap();
        bit got;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        frame    = frame + 13'd1;
        wait_ack(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL swap_ack_timeout: got no ack, required ack");
        end
    endtask

    // Presents the predecessor pixel for one cycle so the prefetch targets (px,py), then samples.
    task automatic get_pixel(input logic [5:0] px, input logic [5:0] py, input logic [3:0] ph,
                             output logic [2:0] r0, output logic [2:0] r1);
        logic [4:0] prow;
        subframe = {4'd0, ph};
        if (px == 6'd0) begin
            prow = py[4:0] - 5'd1;
            x    = 6'd63;
            y    = {py[5], prow};
        end else begin
            x = px - 6'd1;
            y = py;
        end
        step();
        x = px;
        y = py;
        @(negedge clk);
        r0 = rgb0;
        r1 = rgb1;
    endtask

    task automatic test_reset();
        logic [2:0] r0, r1;
        resetn = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({wr_ready0, wr_ready1, swap_ack0, swap_ack1, rgb0, rgb1} !== 10'b11_00_000_000) begin
            failures++;
            $display("FAIL reset_outputs: got %b required %b",
                     {wr_ready0, wr_ready1, swap_ack0, swap_ack1, rgb0, rgb1}, 10'b11_00_000_000);
        end
        step();
        resetn = 1'b1;
        step();
        get_pixel(6'd0, 6'd0, 4'd0, r0, r1);
        checks++;
        if ({r0, r1} !== 6'b000_000) begin
            failures++;
            $display("FAIL noswap_px0: got %b required 000000", {r0, r1});
        end
        get_pixel(6'd5, 6'd40, 4'd3, r0, r1);
        checks++;
        if ({r0, r1} !== 6'b000_000) begin
            failures++;
            $display("FAIL noswap_px1: got %b required 000000", {r0, r1});
        end
        get_pixel(6'd63, 6'd31, 4'd15, r0, r1);
        checks++;
        if ({r0, r1, wr_ready0, wr_ready1} !== 8'b000_000_11) begin
            failures++;
            $display("FAIL noswap_px2: got %b required 00000011", {r0, r1, wr_ready0, wr_ready1});
        end
    endtask

    task automatic test_swap_basic();
        logic [2:0] r0, r1, exp;
        do_write(6'd3, 6'd5, 12'hF00);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ready0 !== 1'b0) begin
            failures++;
            $display("FAIL pending_ready: got %b required 0", wr_ready0);
        end
        step();
        step();
        @(negedge clk);
        checks++;
        if (swap_ack0 !== 1'b0) begin
            failures++;
            $display("FAIL early_ack: got %b required 0", swap_ack0);
        end
        frame = frame + 13'd1;
        step();
        @(negedge clk);
        checks++;
        if ({swap_ack0, swap_ack1} !== 2'b11) begin
            failures++;
            $display("FAIL ack_timing: got %b required 11", {swap_ack0, swap_ack1});
        end
        step();
        @(negedge clk);
        checks++;
        if ({swap_ack0, wr_ready0} !== 2'b01) begin
            failures++;
            $display("FAIL ack_pulse_end: got %b required 01", {swap_ack0, wr_ready0});
        end
        for (int ph = 0; ph < 16; ph++) begin
            get_pixel(6'd3, 6'd5, 4'(ph), r0, r1);
            exp = (ph < 15) ? 3'b100 : 3'b000;
            checks++;
            if ({r0, r1} !== {exp, 3'b000}) begin
                failures++;
                $display("FAIL red_pwm ph=%0d: got %b required %b", ph, {r0, r1}, {exp, 3'b000});
            end
        end
    endtask

    task automatic test_scan_row();
        logic [2:0] exp;
        for (int i = 0; i < 64; i++) begin
            do_write(6'(i), 6'd2, (i == 10) ? 12'h080 : 12'h000);
        end
        do_write(6'd0, 6'd3, 12'h000);
        do_write(6'd7, 6'd9, 12'h000);
        do_swap();
        for (int p = 7; p <= 8; p++) begin
            subframe = 8'(p);
            x = 6'd63;
            y = 6'd1;
            step();
            for (int i = 0; i < 64; i++) begin
                x = 6'(i);
                y = 6'd2;
                @(negedge clk);
                exp = (i == 10 && p < 8) ? 3'b010 : 3'b000;
                checks++;
                if (rgb0 !== exp) begin
                    failures++;
                    $display("FAIL row_scan ph=%0d x=%0d: got %b required %b", p, i, rgb0, exp);
                end
                step();
            end
            step();
            step();
            x = 6'd0;
            y = 6'd3;
            @(negedge clk);
            checks++;
            if (rgb0 !== 3'b000) begin
                failures++;
                $display("FAIL row_change ph=%0d: got %b required 000", p, rgb0);
            end
        end
    endtask

    task automatic test_pending();
        logic [2:0] r0, r1;
        int acks = 0;
        do_write(6'd7, 6'd9, 12'h00F);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        swap_req = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready0 !== 1'b0) begin
            failures++;
            $display("FAIL pending_ready2: got %b required 0", wr_ready0);
        end
        step();
        swap_req = 1'b0;
        frame    = frame + 13'd1;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            if (swap_ack0) acks++;
        end
        checks++;
        if (acks != 1 || wr_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL single_ack: got acks=%0d ready=%b required acks=1 ready=1", acks, wr_ready0);
        end
        get_pixel(6'd7, 6'd9, 4'd0, r0, r1);
        checks++;
        if (r0 !== 3'b001) begin
            failures++;
            $display("FAIL front_toggle_once: got %b required 001", r0);
        end
    endtask

    task automatic test_half();
        logic [2:0] r0, r1;
        do_write(6'd20, 6'd5,  12'hFFF);
        do_write(6'd20, 6'd37, 12'h000);
        do_write(6'd21, 6'd37, 12'hFFF);
        do_write(6'd21, 6'd5,  12'h000);
        do_swap();
        get_pixel(6'd20, 6'd5, 4'd0, r0, r1);
        checks++;
        if ({r0, r1} !== 6'b111_000) begin
            failures++;
            $display("FAIL half0_col20: got %b required 111000", {r0, r1});
        end
        get_pixel(6'd21, 6'd5, 4'd0, r0, r1);
        checks++;
        if ({r0, r1} !== 6'b000_000) begin
            failures++;
            $display("FAIL half0_col21: got %b required 000000", {r0, r1});
        end
        get_pixel(6'd20, 6'd37, 4'd0, r0, r1);
        checks++;
        if ({r0, r1} !== 6'b000_000) begin
            failures++;
            $display("FAIL half1_col20: got %b required 000000", {r0, r1});
        end
        get_pixel(6'd21, 6'd37, 4'd0, r0, r1);
        checks++;
        if ({r0, r1} !== 6'b000_111) begin
            failures++;
            $display("FAIL half1_col21: got %b required 000111", {r0, r1});
        end
    endtask

    task automatic test_write_swap_same_cycle();
        logic [2:0] r0, r1;
        bit got;
        frame = 13'd8191;
        step();
        wr_valid = 1'b1;
        wr_x     = 6'd30;
        wr_y     = 6'd12;
        wr_data  = 12'h0F0;
        swap_req = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_ready: got %b required 1", wr_ready0);
        end
        step();
        wr_valid = 1'b0;
        swap_req = 1'b0;
        frame    = frame + 13'd1;
        wait_ack(got);
        checks++;
        if (!got || frame !== 13'd0) begin
            failures++;
            $display("FAIL wrap_boundary: got ack=%b required ack=1", got);
        end
        get_pixel(6'd30, 6'd12, 4'd0, r0, r1);
        checks++;
        if (r0 !== 3'b010) begin
            failures++;
            $display("FAIL write_then_swap: got %b required 010", r0);
        end
    endtask

    task automatic test_coincident_gamma();
        logic [2:0] r0, r1, exp;
        bit got;
        int acks = 0;
        int lit_lim;
`ifdef FB_GAMMA_EN
        lit_lim = 1;
`else
        lit_lim = 4;
`endif
        do_write(6'd40, 6'd20, 12'h400);
        swap_req = 1'b1;
        frame    = frame + 13'd1;
        step();
        swap_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (swap_ack0) acks++;
            step();
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL coincident_no_ack: got acks=%0d required 0", acks);
        end
        frame = frame + 13'd1;
        wait_ack(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL coincident_next_boundary: got no ack, required ack");
        end
        for (int ph = 0; ph < 6; ph++) begin
            get_pixel(6'd40, 6'd20, 4'(ph), r0, r1);
            exp = (ph < lit_lim) ? 3'b100 : 3'b000;
            checks++;
            if (r0 !== exp) begin
                failures++;
                $display("FAIL level4_pwm ph=%0d: got %b required %b", ph, r0, exp);
            end
        end
    endtask

    task automatic test_reset_pending();
        logic [2:0] r0, r1;
        int acks = 0;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if ({wr_ready0, swap_ack0} !== 2'b10) begin
            failures++;
            $display("FAIL reset_mid_pending: got %b required 10", {wr_ready0, swap_ack0});
        end
        step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame = frame + 13'd1;
            step();
            @(negedge clk);
            if (swap_ack0 || swap_ack1) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL lost_request: got acks=%0d required 0", acks);
        end
        get_pixel(6'd40, 6'd20, 4'd0, r0, r1);
        checks++;
        if ({r0, r1} !== 6'b000_000) begin
            failures++;
            $display("FAIL blank_after_reset: got %b required 000000", {r0, r1});
        end
    endtask

    initial begin
        resetn   = 1'b0;
        frame    = 13'd0;
        subframe = 8'd0;
        x        = 6'd0;
        y        = 6'd0;
        wr_valid = 1'b0;
        wr_x     = 6'd0;
        wr_y     = 6'd0;
        wr_data  = 12'h000;
        swap_req = 1'b0;
        test_reset();
        test_swap_basic();
        test_scan_row();
        test_pending();
        test_half();
        test_write_swap_same_cycle();
        test_coincident_gamma();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
